// File: rtl/mantissa_multiplier_seq.sv
// Iterative shift-and-add mantissa multiplier: one conditional add per clock, full product
// plus normalized mantissa and exponent-increment flag. Define MANT_ROUND_EN for round-to-nearest-even.
module mantissa_multiplier_seq #(
   parameter int BIT_WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BIT_WIDTH-1:0]     in0,
   input  logic [BIT_WIDTH-1:0]     in1,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*BIT_WIDTH-1:0]   product,
   output logic [BIT_WIDTH-1:0]     mant_out,
   output logic                     exp_inc,
   output logic [1:0]               dbg_state
);
   localparam int W  = BIT_WIDTH;
   localparam int PW = 2 * BIT_WIDTH;
   localparam int CW = $clog2(BIT_WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.
   logic [1:0]    state_q,   state_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic [PW-1:0] acc_q,     acc_d;
   logic [PW-1:0] mcand_q,   mcand_d;
   logic [W-1:0]  mplier_q,  mplier_d;
   logic [PW-1:0] product_q, product_d;
   logic [W-1:0]  mant_q,    mant_d;
   logic          exp_inc_q, exp_inc_d;

   logic          norm;
   logic [W-1:0]  mant_trunc;
   logic [W-1:0]  mant_fin;
   logic          round_carry;
`ifdef MANT_ROUND_EN
   logic          guard;
   logic          sticky;
   logic          round_up;
`endif

   always_comb begin
      norm       = acc_q[PW-1];
      mant_trunc = norm ? acc_q[PW-1:W] : acc_q[PW-2:W-1];
`ifdef MANT_ROUND_EN
      guard       = norm ? acc_q[W-1] : acc_q[W-2];
      sticky      = norm ? (|acc_q[W-2:0]) : (|acc_q[W-3:0]);
      round_up    = guard & (sticky | mant_trunc[0]);
      round_carry = round_up & (&mant_trunc);
      // An all-ones mantissa rounding up wraps to 1.000 and bumps the exponent.
      if (round_carry) begin
         mant_fin = {1'b1, {(W-1){1'b0}}};
      end else begin
         mant_fin = mant_trunc + {{(W-1){1'b0}}, round_up};
      end
`else
      round_carry = 1'b0;
      mant_fin    = mant_trunc;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      product_d = product_q;
      mant_d    = mant_q;
      exp_inc_d = exp_inc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = {{W{1'b0}}, in0};
               mplier_d = in1;
               acc_d    = '0;
               cnt_d    = CW'(BIT_WIDTH);
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - 1'b1;
            end else begin
               // Final RUN cycle registers the product and its normalized form.
               product_d = acc_q;
               mant_d    = mant_fin;
               exp_inc_d = norm | round_carry;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         mant_q    <= '0;
         exp_inc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
         mant_q    <= mant_d;
         exp_inc_q <= exp_inc_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign product   = product_q;
   assign mant_out  = mant_q;
   assign exp_inc   = exp_inc_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// Self-checking bench for mantissa_multiplier_seq at BIT_WIDTH=5: vector table, corner
// sequences (stall, mid-run reset) and random operands against an arithmetic reference model.
module tb_mantissa_multiplier_seq;
   localparam int W  = 5;
   localparam int PW = 2 * W;
   localparam int RW = PW + W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in0;
   logic [W-1:0]  in1;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] product;
   logic [W-1:0]  mant_out;
   logic          exp_inc;
   logic [1:0]    dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [RW-1:0] exp_q[$];

   mantissa_multiplier_seq #(.BIT_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .mant_out(mant_out), .exp_inc(exp_inc), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] prod;
      logic [W-1:0]  mant;
      logic          e;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // reference model: exact product, then normalize/round from plain arithmetic
   function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] p, mant, rem, half;
      logic        e;
      p = 64'(a) * 64'(b);
      if (p >= (64'd1 << (PW - 1))) begin
         mant = p >> W;
         rem  = p % (64'd1 << W);
         half = 64'd1 << (W - 1);
         e    = 1'b1;
      end else begin
         mant = p >> (W - 1);
         rem  = p % (64'd1 << (W - 1));
         half = 64'd1 << (W - 2);
         e    = 1'b0;
      end
`ifdef MANT_ROUND_EN
      if (rem > half || (rem == half && mant[0])) mant = mant + 1;
      if (mant == (64'd1 << W)) begin
         mant = 64'd1 << (W - 1);
         e    = 1'b1;
      end
`else
      if (rem > half) mant = mant;
`endif
      return {p[PW-1:0], mant[W-1:0], e};
   endfunction

   // drivers
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in0      = a;
      in1      = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // returns at a negedge; lat = rising edges since the accept edge
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid) lat++;
      end
      if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
   endtask

   task automatic take_result(input string name, input logic [RW-1:0] want);
      check({name, "_product"}, 64'(product), 64'(want[RW-1:W+1]));
      check({name, "_mant"}, 64'(mant_out), 64'(want[W:1]));
      check({name, "_exp_inc"}, 64'(exp_inc), 64'(want[0]));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int            lat;
      logic [W-1:0]  a, b;
      logic [RW-1:0] want;
      logic [PW-1:0] held_p;

      tbl[0] = '{a: 5'b01100, b: 5'b00100, prod: 10'b0000110000, mant: 5'b00011, e: 1'b0};
      tbl[1] = '{a: 5'b11111, b: 5'b11111, prod: 10'b1111000001, mant: 5'b11110, e: 1'b1};
`ifdef MANT_ROUND_EN
      tbl[2] = '{a: 5'b10011, b: 5'b10011, prod: 10'b0101101001, mant: 5'b10111, e: 1'b0};
      tbl[3] = '{a: 5'b10111, b: 5'b10110, prod: 10'b0111111010, mant: 5'b10000, e: 1'b1};
`else
      tbl[2] = '{a: 5'b10011, b: 5'b10011, prod: 10'b0101101001, mant: 5'b10110, e: 1'b0};
      tbl[3] = '{a: 5'b10111, b: 5'b10110, prod: 10'b0111111010, mant: 5'b11111, e: 1'b0};
`endif
      tbl[4] = '{a: 5'b10000, b: 5'b10000, prod: 10'b0100000000, mant: 5'b10000, e: 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in0 = '0; in1 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_product", 64'(product), 64'd0);
      check("reset_mant", 64'(mant_out), 64'd0);
      check("reset_exp_inc", 64'(exp_inc), 64'd0);

      // vector table
      for (int i = 0; i < 5; i++) begin
         start_op(tbl[i].a, tbl[i].b);
         wait_done(lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
         take_result($sformatf("vec%0d", i), {tbl[i].prod, tbl[i].mant, tbl[i].e});
      end

      // stall in DONE with in_valid pulses during RUN
      start_op(5'b10011, 5'b10011);
      repeat (2) begin
         in_valid = 1'b1; in0 = 5'b11111; in1 = 5'b11111;
         @(negedge clk);
         in_valid = 1'b0;
         @(negedge clk);
      end
      wait_done(lat);
      want   = {tbl[2].prod, tbl[2].mant, tbl[2].e};
      held_p = want[RW-1:W+1];
      for (int k = 0; k < 10; k++) begin
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_product", 64'(product), 64'(held_p));
         check("stall_mant", 64'(mant_out), 64'(want[W:1]));
         @(negedge clk);
      end
      out_ready = 1'b1; in_valid = 1'b1; in0 = 5'b11111; in1 = 5'b11111;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("release_out_valid", 64'(out_valid), 64'd0);
      check("release_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b0;

      // reset in the middle of RUN
      start_op(5'b11011, 5'b10101);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_product", 64'(product), 64'd0);
      check("midrst_mant", 64'(mant_out), 64'd0);
      check("midrst_exp_inc", 64'(exp_inc), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start_op(tbl[4].a, tbl[4].b);
      wait_done(lat);
      take_result("after_rst", {tbl[4].prod, tbl[4].mant, tbl[4].e});

      // random operands through the scoreboard
      for (int n = 0; n < 40; n++) begin
         a = W'($urandom_range(0, (1 << W) - 1));
         b = W'($urandom_range(0, (1 << W) - 1));
         if ($urandom_range(0, 3) != 0) a[W-1] = 1'b1;
         if ($urandom_range(0, 3) != 0) b[W-1] = 1'b1;
         exp_q.push_back(model(a, b));
         if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
         start_op(a, b);
         out_ready = 1'b0;
         wait_done(lat);
         check("rand_latency", 64'(lat), 64'(W + 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         take_result($sformatf("rand%0d_%0h_%0h", n, a, b), exp_q.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
